// File: rtl/adder_pkg.sv
// Shared constants for the adder_6bit slice: operand default width, sum width and carry counter width.
package adder_pkg;

    localparam int ADDER_WIDTH = 6;
    localparam int SUM_W       = ADDER_WIDTH + 1;
    localparam int CARRY_CNT_W = 16;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell used as a single stage of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/adder_6bit.sv
// Unsigned ripple-carry adder with a combinational sum and a one-cycle registered sum.
// Optional saturating carry-out counter is built when ADDER_CARRY_CNT_EN is defined.
module adder_6bit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       x,
    input  logic [WIDTH-1:0]       y,
    input  logic                   in_valid,
    output logic [WIDTH:0]         s,
    output logic [WIDTH:0]         s_q,
`ifdef ADDER_CARRY_CNT_EN
    output logic [CARRY_CNT_W-1:0] carry_cnt,
`endif
    output logic                   out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;

    // Stage 0 (combinational): ripple chain, carry-in of the LSB stage tied low
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (carry[i]),
            .sum  (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    assign s = {carry[WIDTH], sum_bits};

    // Stage 1: registered sum; the held value is kept across idle cycles
    logic [WIDTH:0] sum_p1;
    logic           vld_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1 <= s;
            end
        end
    end

    assign s_q       = sum_p1;
    assign out_valid = vld_p1;

`ifdef ADDER_CARRY_CNT_EN
    function automatic logic [CARRY_CNT_W-1:0] sat_inc(input logic [CARRY_CNT_W-1:0] v);
        return (v == {CARRY_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [CARRY_CNT_W-1:0] cnt_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else if (in_valid && s[WIDTH]) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign carry_cnt = cnt_p1;
`endif

endmodule : adder_6bit

// File: tb/tb_adder_6bit.sv
// Scoreboard bench for adder_6bit: exhaustive combinational sweep plus directed registered-path vectors.
module tb_adder_6bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] x;
    logic [5:0] y;
    logic       in_valid;
    logic [6:0] s;
    logic [6:0] s_q;
    logic       out_valid;
`ifdef ADDER_CARRY_CNT_EN
    logic [15:0] carry_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       vld;
        logic [6:0] sq;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference state for the registered path
    logic [6:0] m_sq  = '0;
    int         m_cnt = 0;

    adder_6bit #(.WIDTH(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .in_valid  (in_valid),
        .s         (s),
        .s_q       (s_q),
`ifdef ADDER_CARRY_CNT_EN
        .carry_cnt (carry_cnt),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check7(input string name, input logic [6:0] act, input logic [6:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Drive one edge worth of stimulus; exp_sum is the hand-computed x+y
    task automatic apply(input logic [5:0] ax, input logic [5:0] ay, input logic v,
                         input logic r, input logic [6:0] exp_sum);
        exp_t e;
        @(negedge clk);
        x        = ax;
        y        = ay;
        in_valid = v;
        rst      = r;
        if (r) begin
            m_sq  = '0;
            m_cnt = 0;
            e.vld = 1'b0;
        end else begin
            e.vld = v;
            if (v) begin
                m_sq = exp_sum;
                if (exp_sum[6] && m_cnt < 65535) m_cnt++;
            end
        end
        e.sq  = m_sq;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected record per driven edge, checked just after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== e.vld) begin
                failures++;
                $display("FAIL out_valid actual=%0b required=%0b", out_valid, e.vld);
            end
            checks++;
            if (s_q !== e.sq) begin
                failures++;
                $display("FAIL s_q actual=%0d required=%0d", s_q, e.sq);
            end
`ifdef ADDER_CARRY_CNT_EN
            checks++;
            if (int'(carry_cnt) != e.cnt) begin
                failures++;
                $display("FAIL carry_cnt actual=%0d required=%0d", carry_cnt, e.cnt);
            end
`endif
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        x        = '0;
        y        = '0;
        in_valid = 1'b0;
        rst      = 1'b1;

        apply(6'd0, 6'd0, 1'b0, 1'b1, 7'd0);
        apply(6'd0, 6'd0, 1'b0, 1'b1, 7'd0);
        apply(6'd0, 6'd0, 1'b0, 1'b0, 7'd0);
        repeat (2) @(posedge clk);
        #2;

        // Exhaustive combinational sweep with the registered path idle
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                logic [6:0] req;
                x   = 6'(i);
                y   = 6'(j);
                req = 7'(i + j);
                #1;
                checks++;
                if (s !== req) begin
                    failures++;
                    $display("FAIL sweep x=%0d y=%0d actual=%0d required=%0d", i, j, s, req);
                end
            end
        end

        // Corner values on the combinational sum
        x = 6'd0;  y = 6'd0;  #1; check7("corner_0_0",   s, 7'b0000000);
        x = 6'd32; y = 6'd32; #1; check7("corner_32_32", s, 7'b1000000);
        x = 6'd63; y = 6'd1;  #1; check7("corner_63_1",  s, 7'b1000000);
        x = 6'd63; y = 6'd63; #1; check7("corner_63_63", s, 7'b1111110);

        // Single valid then idle: 14 with valid, then held with valid low
        apply(6'd5, 6'd9, 1'b1, 1'b0, 7'd14);
        apply(6'd0, 6'd0, 1'b0, 1'b0, 7'd0);
        apply(6'd7, 6'd7, 1'b0, 1'b0, 7'd14);

        // Back-to-back valids, including carry-out cases
        apply(6'd63, 6'd1,  1'b1, 1'b0, 7'd64);
        apply(6'd63, 6'd1,  1'b1, 1'b0, 7'd64);
        apply(6'd63, 6'd1,  1'b1, 1'b0, 7'd64);
        apply(6'd1,  6'd1,  1'b1, 1'b0, 7'd2);
        apply(6'd63, 6'd63, 1'b1, 1'b0, 7'd126);
        apply(6'd20, 6'd11, 1'b1, 1'b0, 7'd31);
        apply(6'd0,  6'd0,  1'b0, 1'b0, 7'd0);

        // Reset takes priority over a valid operation in the same cycle
        apply(6'd40, 6'd40, 1'b1, 1'b1, 7'd80);
        #1; check7("s_during_reset", s, 7'd80);
        apply(6'd40, 6'd40, 1'b0, 1'b0, 7'd80);
        #1; check7("s_after_reset", s, 7'd80);
        apply(6'd33, 6'd31, 1'b1, 1'b0, 7'd64);
        apply(6'd0,  6'd0,  1'b0, 1'b0, 7'd0);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adder_6bit
